// File: rtl/seq_restoring_divider_16_if.sv
// Start/done request bundle for the sequential divider; master drives operands, slave returns results.
interface seq_restoring_divider_16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_16.sv
// Restoring divider, one trial subtraction per clock; done pulses WIDTH cycles after the accepting edge
// (next cycle on divide-by-zero); start is ignored while busy. DIV_SIGNED_EN selects two's-complement operands.
module seq_restoring_divider_16 #(
  parameter int WIDTH = 16
) (
  input logic                        clk,
  input logic                        rst,
  seq_restoring_divider_16_if.slave  div_if
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE1 = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_acc_q, rem_acc_d;
  logic [WIDTH-1:0] quo_acc_q, quo_acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] quo_fin, rem_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_acc_q   <= '0;
      quo_acc_q   <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_acc_q   <= rem_acc_d;
      quo_acc_q   <= quo_acc_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_acc_d   = rem_acc_q;
    quo_acc_d   = quo_acc_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif

    // Since rem_acc < B, a non-borrowing trial always fits in WIDTH bits, so trial[WIDTH] is the borrow.
    rem_sh   = {rem_acc_q, quo_acc_q[WIDTH-1]};
    trial    = rem_sh + ~{1'b0, b_q} + ONE1;
    step_rem = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    step_quo = {quo_acc_q[WIDTH-2:0], ~trial[WIDTH]};

    a_mag = div_if.dividend;
    b_mag = div_if.divisor;
`ifdef DIV_SIGNED_EN
    if (div_if.dividend[WIDTH-1]) a_mag = ~div_if.dividend + ONE;
    if (div_if.divisor[WIDTH-1])  b_mag = ~div_if.divisor + ONE;
    quo_fin = neg_quo_q ? (~step_quo + ONE) : step_quo;
    rem_fin = neg_rem_q ? (~step_rem + ONE) : step_rem;
`else
    quo_fin = step_quo;
    rem_fin = step_rem;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (div_if.start) begin
          rem_acc_d = '0;
          quo_acc_d = a_mag;
          b_d       = b_mag;
          cnt_d     = '0;
`ifdef DIV_SIGNED_EN
          neg_quo_d = div_if.dividend[WIDTH-1] ^ div_if.divisor[WIDTH-1];
          neg_rem_d = div_if.dividend[WIDTH-1];
`endif
          if (div_if.divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = div_if.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_RUN;
            dbz_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        rem_acc_d = step_rem;
        quo_acc_d = step_quo;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = S_DONE;
          quotient_d  = quo_fin;
          remainder_d = rem_fin;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign div_if.busy        = (state_q == S_RUN);
  assign div_if.done        = (state_q == S_DONE);
  assign div_if.quotient    = quotient_q;
  assign div_if.remainder   = remainder_q;
  assign div_if.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider_16.sv
// Directed-vector bench for seq_restoring_divider_16; honours DIV_SIGNED_EN for the sign-specific vectors.
module tb_seq_restoring_divider_16;
  logic clk = 1'b0;
  logic rst;

  seq_restoring_divider_16_if #(.WIDTH(16)) dif ();

  seq_restoring_divider_16 #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] mid_q, mid_r;
  int lat, bcnt, seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds start for exactly one rising edge; returns on the following falling edge.
  task automatic go(input logic [15:0] a, input logic [15:0] b);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(negedge clk);
    dif.start    = 1'b0;
  endtask

  task automatic wait_done(input int inj, output int l, output int bc);
    l  = 0;
    bc = 0;
    while (dif.done !== 1'b1 && l < 100) begin
      if (dif.busy === 1'b1) bc++;
      if (l == inj) begin
        dif.start    = 1'b1;
        dif.dividend = 16'd9;
        dif.divisor  = 16'd2;
        mid_q        = dif.quotient;
        mid_r        = dif.remainder;
      end
      if (l == inj + 1) dif.start = 1'b0;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eq, input logic [15:0] er, input logic edz,
                     input int elat, input bit b2b);
    int l, bc;
    if (!b2b) @(negedge clk);
    go(a, b);
    wait_done(-1, l, bc);
    check({tag, "_latency"}, l, elat);
    check({tag, "_busy_cycles"}, bc, elat);
    check({tag, "_quotient"}, dif.quotient, eq);
    check({tag, "_remainder"}, dif.remainder, er);
    check({tag, "_div_by_zero"}, dif.div_by_zero, edz);
  endtask

  initial begin
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    #12;
    check("rst_busy", dif.busy, 0);
    check("rst_done", dif.done, 0);
    check("rst_quotient", dif.quotient, 0);
    check("rst_remainder", dif.remainder, 0);
    check("rst_div_by_zero", dif.div_by_zero, 0);
    rst = 1'b0;

    run("d1000_7", 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 16, 1'b0);
    @(negedge clk);
    check("d1000_7_done_pulse", dif.done, 0);
    check("d1000_7_held_q", dif.quotient, 16'd142);

    run("dFFFF_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16, 1'b0);
    run("d5_9_b2b", 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 16, 1'b1);
    run("d04D2_0", 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 0, 1'b0);

    // Start pulse mid-RUN must be ignored; outputs stay at the previous result until DONE.
    @(negedge clk);
    go(16'd100, 16'd3);
    check("d100_3_dbz_cleared", dif.div_by_zero, 0);
    wait_done(4, lat, bcnt);
    check("d100_3_latency", lat, 16);
    check("d100_3_mid_q_held", mid_q, 16'hFFFF);
    check("d100_3_mid_r_held", mid_r, 16'h04D2);
    check("d100_3_quotient", dif.quotient, 16'd33);
    check("d100_3_remainder", dif.remainder, 16'd1);
    @(negedge clk);
    check("d100_3_no_restart", dif.busy, 0);

    // Asynchronous abort during RUN.
    @(negedge clk);
    go(16'd300, 16'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_quotient", dif.quotient, 0);
    check("abort_remainder", dif.remainder, 0);
    check("abort_busy", dif.busy, 0);
    check("abort_done", dif.done, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (dif.done !== 1'b0 || dif.busy !== 1'b0) seen++;
    end
    check("abort_no_done", seen, 0);
    run("d50_5", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 16, 1'b0);

`ifdef DIV_SIGNED_EN
    run("s_m7_2", 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 16, 1'b0);
    run("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 16, 1'b0);
    run("s_m100_7", 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 16, 1'b0);
`else
    run("u_FFF9_2", 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, 16, 1'b0);
    run("u_8000_FFFF", 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 16, 1'b0);
    run("u_FF9C_7", 16'hFF9C, 16'h0007, 16'h2484, 16'h0000, 1'b0, 16, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
